// File: rtl/data_memory_pkg.sv
// Shared constants and state encoding for the word-organised data memory.
// The MMIO console address is only decoded when DATA_MEM_MMIO_EN is defined.
package Purple_Jade_pkg;

    localparam int          MEM_DEPTH         = 1024;
    localparam logic [15:0] MMIO_CONSOLE_ADDR = 16'hFFFE;

    typedef enum logic {
        DM_CLEAR = 1'b0,
        DM_READY = 1'b1
    } data_mem_state_e;

endpackage

// File: rtl/data_memory_clear_fsm.sv
// Post-reset clear sequencer: sweeps every word index once, then parks in READY.
// o_state is exported so the top (and any checker) sees the raw FSM state.
module data_mem_clear_fsm
    import Purple_Jade_pkg::*;
#(
    parameter int MEM_DEPTH_P      = MEM_DEPTH,
    parameter int CLEAR_ON_RESET_P = 1,
    parameter int IDX_W            = $clog2(MEM_DEPTH_P)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    output data_mem_state_e o_state,
    output logic [IDX_W-1:0] o_clr_idx,
    output logic            o_mem_ready
);

    localparam data_mem_state_e LP_RESET_STATE = (CLEAR_ON_RESET_P != 0) ? DM_CLEAR : DM_READY;
    localparam logic [IDX_W-1:0] LP_LAST_IDX   = IDX_W'(MEM_DEPTH_P - 1);

    data_mem_state_e  r_state;
    data_mem_state_e  w_next_state;
    logic [IDX_W-1:0] r_clr_idx;
    logic [IDX_W-1:0] w_next_idx;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= LP_RESET_STATE;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_next_state;
            r_clr_idx <= w_next_idx;
        end
    end

    // The zero write for r_clr_idx happens this cycle; leave once the last index is written.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_clr_idx;
        case (r_state)
            DM_CLEAR: begin
                w_next_idx = r_clr_idx + IDX_W'(1);
                if (r_clr_idx == LP_LAST_IDX) begin
                    w_next_state = DM_READY;
                end
            end
            DM_READY: begin
                w_next_state = DM_READY;
            end
            default: begin
                w_next_state = LP_RESET_STATE;
            end
        endcase
    end

    assign o_state     = r_state;
    assign o_clr_idx   = r_clr_idx;
    assign o_mem_ready = (r_state == DM_READY);

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory with post-reset clear, same-cycle write forwarding
// and a saturating store counter. Optional console port under DATA_MEM_MMIO_EN.
module data_memory
    import Purple_Jade_pkg::*;
#(
    parameter int WORD_SIZE_P      = 16,
    parameter int MEM_DEPTH_P      = MEM_DEPTH,
    parameter int CLEAR_ON_RESET_P = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   data_mem_w_v_i,
    input  logic [WORD_SIZE_P-1:0] data_mem_w_addr_i,
    input  logic [WORD_SIZE_P-1:0] data_mem_w_data_i,
    input  logic                   data_mem_r_v_i,
    input  logic [WORD_SIZE_P-1:0] data_mem_r_addr_i,
    output logic [WORD_SIZE_P-1:0] data_mem_r_data_o,
    output logic                   mem_ready_o,
    output logic                   mem_drop_err_o,
`ifdef DATA_MEM_MMIO_EN
    output logic                   mmio_v_o,
    output logic [WORD_SIZE_P-1:0] mmio_data_o,
`endif
    output logic [15:0]            mem_store_cnt_o
);

    localparam int IDX_W = $clog2(MEM_DEPTH_P);

    logic [WORD_SIZE_P-1:0] r_mem [MEM_DEPTH_P];
    logic [15:0]            r_store_cnt;
    logic                   r_drop_err;

    data_mem_state_e  w_state;
    logic [IDX_W-1:0] w_clr_idx;
    logic             w_ready;
    logic [IDX_W-1:0] w_widx;
    logic [IDX_W-1:0] w_ridx;
    logic             w_is_mmio_w;
    logic             w_is_mmio_r;
    logic             w_store;

    data_mem_clear_fsm #(
        .MEM_DEPTH_P      (MEM_DEPTH_P),
        .CLEAR_ON_RESET_P (CLEAR_ON_RESET_P),
        .IDX_W            (IDX_W)
    ) u_clear_fsm (
        .i_clk       (clk_i),
        .i_reset     (reset_i),
        .o_state     (w_state),
        .o_clr_idx   (w_clr_idx),
        .o_mem_ready (w_ready)
    );

    // Bit 0 and the bits above the index are deliberately dropped: addresses alias.
    assign w_widx = data_mem_w_addr_i[IDX_W:1];
    assign w_ridx = data_mem_r_addr_i[IDX_W:1];

    logic w_unused_addr_bits;
    assign w_unused_addr_bits = &{1'b0,
                                  data_mem_w_addr_i[WORD_SIZE_P-1:IDX_W+1], data_mem_w_addr_i[0],
                                  data_mem_r_addr_i[WORD_SIZE_P-1:IDX_W+1], data_mem_r_addr_i[0]};

`ifdef DATA_MEM_MMIO_EN
    localparam logic [WORD_SIZE_P-1:0] LP_MMIO_ADDR = WORD_SIZE_P'(MMIO_CONSOLE_ADDR);

    logic                   r_mmio_v;
    logic [WORD_SIZE_P-1:0] r_mmio_data;

    assign w_is_mmio_w = (data_mem_w_addr_i == LP_MMIO_ADDR);
    assign w_is_mmio_r = (data_mem_r_addr_i == LP_MMIO_ADDR);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_mmio_v    <= 1'b0;
            r_mmio_data <= '0;
        end else begin
            r_mmio_v    <= w_ready && data_mem_w_v_i && w_is_mmio_w;
            r_mmio_data <= (w_ready && data_mem_w_v_i && w_is_mmio_w) ? data_mem_w_data_i : '0;
        end
    end

    assign mmio_v_o    = r_mmio_v;
    assign mmio_data_o = r_mmio_data;
`else
    assign w_is_mmio_w = 1'b0;
    assign w_is_mmio_r = 1'b0;
`endif

    assign w_store = w_ready && data_mem_w_v_i && !w_is_mmio_w;

    // Single write port: the clear sweep and committed stores never overlap in time.
    always_ff @(posedge clk_i) begin
        if (w_state == DM_CLEAR) begin
            r_mem[w_clr_idx] <= '0;
        end else if (w_store) begin
            r_mem[w_widx] <= data_mem_w_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_store_cnt <= '0;
            r_drop_err  <= 1'b0;
        end else begin
            if (w_store && (r_store_cnt != 16'hFFFF)) begin
                r_store_cnt <= r_store_cnt + 16'd1;
            end
            if (data_mem_w_v_i && !w_ready) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    always_comb begin
        data_mem_r_data_o = '0;
        if (w_ready && data_mem_r_v_i && !w_is_mmio_r) begin
            if (w_store && (w_widx == w_ridx)) begin
                data_mem_r_data_o = data_mem_w_data_i;
            end else begin
                data_mem_r_data_o = r_mem[w_ridx];
            end
        end
    end

    assign mem_ready_o     = w_ready;
    assign mem_drop_err_o  = r_drop_err;
    assign mem_store_cnt_o = r_store_cnt;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: clear timing, dropped writes, forwarding,
// aliasing, counter saturation, mid-clear reset and (with DATA_MEM_MMIO_EN) the console port.
module tb_data_memory;

    logic        clk;
    logic        reset;
    logic        w_v;
    logic [15:0] w_addr;
    logic [15:0] w_data;
    logic        r_v;
    logic [15:0] r_addr;
    logic [15:0] r_data;
    logic        mem_ready;
    logic        drop_err;
    logic [15:0] store_cnt;
    logic        mmio_v;
    logic [15:0] mmio_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    data_memory dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .data_mem_w_v_i    (w_v),
        .data_mem_w_addr_i (w_addr),
        .data_mem_w_data_i (w_data),
        .data_mem_r_v_i    (r_v),
        .data_mem_r_addr_i (r_addr),
        .data_mem_r_data_o (r_data),
        .mem_ready_o       (mem_ready),
        .mem_drop_err_o    (drop_err),
`ifdef DATA_MEM_MMIO_EN
        .mmio_v_o          (mmio_v),
        .mmio_data_o       (mmio_data),
`endif
        .mem_store_cnt_o   (store_cnt)
    );

`ifndef DATA_MEM_MMIO_EN
    assign mmio_v    = 1'b0;
    assign mmio_data = 16'h0000;
`endif

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver: inputs change 1 time unit after the rising edge
    task automatic drive(input logic wv, input logic [15:0] wa, input logic [15:0] wd,
                         input logic rv, input logic [15:0] ra);
        w_v = wv; w_addr = wa; w_data = wd; r_v = rv; r_addr = ra;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: expected read pushed at drive time, popped when the read is sampled
    task automatic sb_read_check(input string name);
        logic [15:0] e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(name, {16'h0, r_data}, {16'h0, e});
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick();
        reset = 1'b0;
    endtask

    task automatic count_to_ready(output int k);
        k = 0;
        while (!mem_ready && k < 2000) begin
            tick();
            k++;
        end
    endtask

    typedef struct {
        string       name;
        logic        w_v;
        logic [15:0] w_addr;
        logic [15:0] w_data;
        logic        r_v;
        logic [15:0] r_addr;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int k;
        int base_cnt;
        logic [15:0] last_a;
        logic [15:0] last_d;

        reset = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick();
        tick();
        chk("reset_ready", {31'h0, mem_ready}, 32'd0);
        chk("reset_drop_err", {31'h0, drop_err}, 32'd0);
        chk("reset_cnt", {16'h0, store_cnt}, 32'd0);
        chk("reset_mmio_v", {31'h0, mmio_v}, 32'd0);
        reset = 1'b0;

        // clear sweep with a dropped write at cycle 5 and a gated read during CLEAR
        k = 0;
        while (!mem_ready && k < 2000) begin
            if (k == 5) begin
                chk("drop_err_before", {31'h0, drop_err}, 32'd0);
                drive(1'b1, 16'h0004, 16'hBEEF, 1'b1, 16'h0010);
            end else begin
                drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0010);
            end
            if (k == 6) chk("drop_err_set", {31'h0, drop_err}, 32'd1);
            if (k == 10) chk("read_during_clear", {16'h0, r_data}, 32'd0);
            tick();
            k++;
        end
        chk("clear_cycles", k, 32'd1024);
        chk("drop_err_sticky", {31'h0, drop_err}, 32'd1);
        chk("cnt_after_drop", {16'h0, store_cnt}, 32'd0);

        vecs[0]  = '{"rd_0010_zero",   1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 16'h0000};
        vecs[1]  = '{"rd_dropped",     1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0004, 16'h0000};
        vecs[2]  = '{"wr_0022",        1'b1, 16'h0022, 16'h1234, 1'b1, 16'h0030, 16'h0000};
        vecs[3]  = '{"rd_0022",        1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0022, 16'h1234};
        vecs[4]  = '{"rd_0023_bit0",   1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0023, 16'h1234};
        vecs[5]  = '{"rd_0822_alias",  1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0822, 16'h1234};
        vecs[6]  = '{"wr40_rd42",      1'b1, 16'h0040, 16'hA5A5, 1'b1, 16'h0042, 16'h0000};
        vecs[7]  = '{"fwd_0042",       1'b1, 16'h0042, 16'h1111, 1'b1, 16'h0042, 16'h1111};
        vecs[8]  = '{"wr44_rd40",      1'b1, 16'h0044, 16'h2222, 1'b1, 16'h0040, 16'hA5A5};
        vecs[9]  = '{"rd_not_valid",   1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0022, 16'h0000};
        vecs[10] = '{"fwd_alias",      1'b1, 16'h0822, 16'h7777, 1'b1, 16'h0023, 16'h7777};
        vecs[11] = '{"rd_0022_new",    1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0022, 16'h7777};
        vecs[12] = '{"rd_fffe_clear",  1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFE, 16'h0000};
`ifdef DATA_MEM_MMIO_EN
        vecs[13] = '{"wr_fffe_mmio",   1'b1, 16'hFFFE, 16'h0041, 1'b1, 16'h07FE, 16'h0000};
`else
        vecs[13] = '{"wr_fffe_fwd",    1'b1, 16'hFFFE, 16'h0041, 1'b1, 16'h07FE, 16'h0041};
`endif

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].w_v, vecs[i].w_addr, vecs[i].w_data, vecs[i].r_v, vecs[i].r_addr);
            exp_q.push_back(vecs[i].exp);
            sb_read_check(vecs[i].name);
            tick();
        end

        // cycle right after the 0xFFFE write
        drive(1'b0, 16'h0, 16'h0, 1'b1, 16'hFFFE);
`ifdef DATA_MEM_MMIO_EN
        chk("mmio_v_pulse", {31'h0, mmio_v}, 32'd1);
        chk("mmio_data", {16'h0, mmio_data}, 32'h0041);
        chk("cnt_table", {16'h0, store_cnt}, 32'd5);
        exp_q.push_back(16'h0000);
`else
        chk("mmio_v_absent", {31'h0, mmio_v}, 32'd0);
        chk("cnt_table", {16'h0, store_cnt}, 32'd6);
        exp_q.push_back(16'h0041);
`endif
        sb_read_check("rd_fffe_after");
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h07FE);
        chk("mmio_v_one_cycle", {31'h0, mmio_v}, 32'd0);
`ifdef DATA_MEM_MMIO_EN
        exp_q.push_back(16'h0000);
`else
        exp_q.push_back(16'h0041);
`endif
        sb_read_check("rd_1023");
        tick();

        // saturation burst
        base_cnt = int'(store_cnt);
        last_a = 16'h0;
        last_d = 16'h0;
        for (int i = 0; i < 70000; i++) begin
            last_a = 16'($urandom_range(0, 16'h7FFE)) & 16'hFFFE;
            last_d = 16'($urandom_range(0, 16'hFFFF));
            drive(1'b1, last_a, last_d, 1'b0, 16'h0);
            tick();
            if (i == 99) chk("cnt_plus_100", {16'h0, store_cnt}, 32'(base_cnt + 100));
        end
        chk("cnt_saturated", {16'h0, store_cnt}, 32'h0000FFFF);
        drive(1'b0, 16'h0, 16'h0, 1'b1, last_a);
        exp_q.push_back(last_d);
        sb_read_check("rd_last_burst");
        tick();
        chk("cnt_held", {16'h0, store_cnt}, 32'h0000FFFF);

        // reset partway through the clear sweep
        apply_reset();
        chk("rst2_cnt", {16'h0, store_cnt}, 32'd0);
        chk("rst2_drop_err", {31'h0, drop_err}, 32'd0);
        repeat (300) tick();
        chk("mid_clear_not_ready", {31'h0, mem_ready}, 32'd0);
        apply_reset();
        count_to_ready(k);
        chk("restart_clear_cycles", k, 32'd1024);
        drive(1'b0, 16'h0, 16'h0, 1'b1, last_a);
        exp_q.push_back(16'h0000);
        sb_read_check("rd_after_reclear");
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-organised data memory: the responder for the commit-stage memory interface.
- Accepts one committed store per cycle from the store-buffer drain path.
- Serves one load read per cycle to the execute memory path. Read data is returned combinationally in the same cycle.
- Zero-fills itself after reset through a clear state machine, forwards same-cycle writes to a matching read, and keeps a saturating committed-store counter for debug.

Parameters:
WORD_SIZE_P, 16, data and address width in bits
MEM_DEPTH_P, 1024, number of words; power of two
CLEAR_ON_RESET_P, 1, 1 = run clear FSM after reset; 0 = go straight to READY, contents unchanged

Ports:
clk_i  input  1  clock
reset_i  input  1  synchronous active-high reset
data_mem_w_v_i  input  1  store write valid
data_mem_w_addr_i  input  WORD_SIZE_P  store byte address
data_mem_w_data_i  input  WORD_SIZE_P  store data
data_mem_r_v_i  input  1  load read valid
data_mem_r_addr_i  input  WORD_SIZE_P  load byte address
data_mem_r_data_o  output  WORD_SIZE_P  load data, same cycle
mem_ready_o  output  1  memory initialised and accepting accesses
mem_drop_err_o  output  1  sticky: a write arrived while not READY
mem_store_cnt_o  output  16  saturating count of performed stores

Behaviour:
- One clock, clk_i. reset_i is synchronous and active-high.
- Address mapping: word index = addr[$clog2(MEM_DEPTH_P):1].
  - Bit 0 is ignored; only word-aligned accesses are supported.
  - Upper bits beyond the index are ignored, so addresses alias/wrap modulo 2*MEM_DEPTH_P bytes.
- FSM states: CLEAR, READY.
  - Reset: state = CLEAR if CLEAR_ON_RESET_P, else READY. clr_idx=0, mem_drop_err_o=0, mem_store_cnt_o=0.
  - CLEAR: each cycle writes 0 to mem[clr_idx], then clr_idx++. After writing index MEM_DEPTH_P-1, go to READY. This takes exactly MEM_DEPTH_P cycles.
  - READY: terminal until the next reset.
  - reset_i asserted mid-CLEAR restarts the clear from index 0.
- mem_ready_o = (state==READY). It is registered, so it is 0 in the reset cycle and during all of CLEAR.
- Write, READY only: if data_mem_w_v_i, then mem[widx] <= w_data at the clock edge, and mem_store_cnt_o increments, saturating at 16'hFFFF.
- Write while not READY:
  - The write is dropped; memory and counter are unchanged.
  - mem_drop_err_o is set to 1 at the next edge and is held until reset.
- Read, combinational:
  - If state != READY or !data_mem_r_v_i: data_mem_r_data_o = 0.
  - Else if data_mem_w_v_i and widx==ridx: data_mem_r_data_o = w_data (write-forwarding).
  - Else: data_mem_r_data_o = mem[ridx].
- Simultaneous read and write to different indices are independent.
- Reset does not alter memory contents except through the CLEAR sweep.
- Out-of-range upper address bits never cause an error; they alias.

Optional Feature:
- Macro: DATA_MEM_MMIO_EN.
- Defined:
  - Adds output ports mmio_v_o (1) and mmio_data_o (WORD_SIZE_P).
  - A READY write whose full address equals 16'hFFFE is not stored in the array and is not counted.
  - That write instead drives mmio_v_o=1 and mmio_data_o=w_data for exactly one cycle, registered and visible the cycle after the write.
  - A read of 16'hFFFE returns 0.
  - Both MMIO outputs reset to 0.
- Not defined:
  - The ports are absent.
  - 16'hFFFE is an ordinary address aliasing to index MEM_DEPTH_P-1 under the default depth.

Decomposition:
- Shared package (Purple_Jade_pkg):
  - MEM_DEPTH constant.
  - MMIO_CONSOLE_ADDR constant (16'hFFFE).
  - data_mem_state_e enum {DM_CLEAR, DM_READY}.
- One natural sub-module, data_mem_clear_fsm: owns state, clr_idx and mem_ready_o, and supplies the clear write port.
- The array, forwarding mux and counter stay in data_memory.

Test Plan:
- Reset then idle → mem_ready_o=0 for exactly 1024 cycles after reset deassert, then 1; a read of 0x0010 then returns 0x0000.
- Write during CLEAR: w_v=1, addr=0x0004, data=0xBEEF at cycle 5 → mem_drop_err_o=1 from cycle 6 and sticky; after READY, a read of 0x0004 = 0x0000; mem_store_cnt_o=0.
- READY: write 0x0022←0x1234, next cycle read 0x0022 → 0x1234; read 0x0023 → 0x1234 (bit 0 ignored); read 0x0822 → 0x1234 (alias at depth 1024).
- Same-cycle write 0x0040←0xA5A5 and read 0x0040 → r_data=0xA5A5 that cycle; simultaneous read 0x0042 → prior contents.
- 70000 consecutive READY writes → mem_store_cnt_o saturates at 0xFFFF; reset_i mid-CLEAR at index 300 → clear restarts, READY after a further 1024 cycles.
- With DATA_MEM_MMIO_EN: write 0xFFFE←0x0041 → mmio_v_o=1, mmio_data_o=0x0041 for one cycle; mem[1023] unchanged; counter unchanged.
